// File: rtl/lsu_mem_stage.sv
// Memory-access stage between execute and writeback: runs RV32I loads/stores over a
// variable-latency req/ack data port and emits one registered writeback record per instruction.
module lsu_mem_stage #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_inst,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_rs2_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        exc_misalign,
    output logic        exc_timeout
);
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_ALU     = 7'b0110011;
    localparam logic [6:0] OPC_ALU_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [31:0]      acc_addr;
    logic [2:0]       acc_funct3;
    logic [4:0]       acc_rd;
    logic             acc_load;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        unused_inst_bits;
    logic        is_load;
    logic        is_store;
    logic        writes_rd;
    logic        access_ok;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign opcode           = ex_inst[6:0];
    assign rd               = ex_inst[11:7];
    assign funct3           = ex_inst[14:12];
    assign unused_inst_bits = ^ex_inst[31:15];
    assign ex_ready         = (state == IDLE);
    assign cnt_inc          = cnt + 1'b1;

    // Decode, alignment check and store lane steering for the incoming instruction.
    always_comb begin
        is_load   = (opcode == OPC_LOAD);
        is_store  = (opcode == OPC_STORE);
        writes_rd = (opcode == OPC_ALU) || (opcode == OPC_ALU_IMM) ||
                    (opcode == OPC_LUI) || (opcode == OPC_AUIPC);
        access_ok = 1'b0;
        st_wdata  = ex_rs2_data;
        st_wstrb  = 4'b1111;
        case (funct3)
            3'b000: begin
                access_ok = 1'b1;
                st_wdata  = {4{ex_rs2_data[7:0]}};
                st_wstrb  = 4'b0001 << ex_result[1:0];
            end
            3'b001: begin
                access_ok = ~ex_result[0];
                st_wdata  = {2{ex_rs2_data[15:0]}};
                st_wstrb  = 4'b0011 << ex_result[1:0];
            end
            3'b010:  access_ok = (ex_result[1:0] == 2'b00);
            3'b100:  access_ok = is_load;
            3'b101:  access_ok = is_load & ~ex_result[0];
            default: access_ok = 1'b0;
        endcase
    end

    // Load lane extraction from the returned word using the latched address.
    always_comb begin
        ld_byte = dmem_rdata[{acc_addr[1:0], 3'b000} +: 8];
        ld_half = dmem_rdata[{acc_addr[1], 4'b0000} +: 16];
        case (acc_funct3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            acc_addr     <= '0;
            acc_funct3   <= '0;
            acc_rd       <= '0;
            acc_load     <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            dmem_wstrb   <= '0;
            wb_valid     <= 1'b0;
            wb_we        <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            exc_misalign <= 1'b0;
            exc_timeout  <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            exc_misalign <= 1'b0;
            exc_timeout  <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid) begin
                        wb_rd <= rd;
                        if (is_load || is_store) begin
                            if (access_ok) begin
                                state      <= ACCESS;
                                cnt        <= '0;
                                dmem_req   <= 1'b1;
                                dmem_we    <= is_store;
                                dmem_addr  <= {ex_result[31:2], 2'b00};
                                dmem_wdata <= st_wdata;
                                dmem_wstrb <= is_store ? st_wstrb : 4'b0000;
                                acc_addr   <= ex_result;
                                acc_funct3 <= funct3;
                                acc_rd     <= rd;
                                acc_load   <= is_load;
                            end else begin
                                wb_valid     <= 1'b1;
                                wb_we        <= 1'b0;
                                wb_data      <= ex_result;
                                exc_misalign <= 1'b1;
                            end
                        end else begin
                            wb_valid <= 1'b1;
                            wb_we    <= writes_rd && (rd != 5'd0);
                            wb_data  <= ex_result;
                        end
                    end
                end
                ACCESS: begin
                    // An ack arriving in the expiry cycle still completes the access.
                    if (dmem_ack) begin
                        state    <= IDLE;
                        dmem_req <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_we    <= acc_load && (acc_rd != 5'd0);
                        wb_data  <= acc_load ? ld_data : acc_addr;
                    end else if ((TIMEOUT_CYC != 0) && (cnt_inc == TIMEOUT_VAL)) begin
                        state       <= IDLE;
                        dmem_req    <= 1'b0;
                        wb_valid    <= 1'b1;
                        wb_we       <= 1'b0;
                        wb_data     <= acc_addr;
                        exc_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Randomized and directed bench for lsu_mem_stage; expected records come from an
// instruction-level model of the RV32I memory rules.
module tb_lsu_mem_stage;
    localparam int TO = 4;
    localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, ALU = 7'b0110011;
    localparam logic [6:0] ALUI = 7'b0010011, LUI = 7'b0110111, AUIPC = 7'b0010111;
    localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        ex_valid = 1'b0, ex_ready;
    logic [31:0] ex_inst = '0, ex_result = '0, ex_rs2_data = '0;
    logic        dmem_req, dmem_we, dmem_ack = 1'b0;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
    logic [3:0]  dmem_wstrb;
    logic        wb_valid, wb_we, exc_misalign, exc_timeout;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    lsu_mem_stage #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_inst(ex_inst), .ex_result(ex_result), .ex_rs2_data(ex_rs2_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .exc_misalign(exc_misalign), .exc_timeout(exc_timeout)
    );

    int n_cmp = 0, n_err = 0, n_txn = 0;
    logic [31:0] last_data, last_addr, last_wdata;
    logic [3:0]  last_wstrb;

    typedef struct {
        bit          mem;
        bit          mis;
        bit          we;
        logic [31:0] data;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Instruction-level reference: access size/sign from funct3, lanes by shifting and masking.
    function automatic exp_t model(input logic [31:0] inst, res, rs2, rdata);
        exp_t        e;
        logic [6:0]  opc;
        int          f3, rd, size, off;
        bit          sgn, legal;
        logic [31:0] v, mask;
        opc = inst[6:0];
        f3  = int'(inst[14:12]);
        rd  = int'(inst[11:7]);
        off = int'(res % 4);
        e = '{mem: 1'b0, mis: 1'b0, we: 1'b0, data: res, wdata: 32'h0, wstrb: 4'h0};
        if (opc == LOAD || opc == STORE) begin
            e.mem = 1'b1;
            legal = 1'b1;
            sgn   = 1'b0;
            size  = 1;
            case (f3)
                0: begin size = 1; sgn = 1'b1; end
                1: begin size = 2; sgn = 1'b1; end
                2: size = 4;
                4: size = 1;
                5: size = 2;
                default: legal = 1'b0;
            endcase
            if (opc == STORE && f3 > 2) legal = 1'b0;
            e.mis = !legal || (res % size != 0);
            if (!e.mis && opc == LOAD) begin
                mask = (size == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * size)) - 32'h1;
                v = (rdata >> (8 * off)) & mask;
                if (sgn && v[8 * size - 1]) v = v | ~mask;
                e.data = v;
                e.we   = (rd != 0);
            end else if (!e.mis) begin
                e.wstrb = 4'(((1 << size) - 1) << off);
                e.wdata = (size == 1) ? rs2[7:0] * 32'h0101_0101 :
                          (size == 2) ? rs2[15:0] * 32'h0001_0001 : rs2;
            end
        end else begin
            e.we = (opc == ALU || opc == ALUI || opc == LUI || opc == AUIPC) && (rd != 0);
        end
        return e;
    endfunction

    // One instruction: present, retire, check. delay >= TO means the memory never acks.
    task automatic do_txn(input logic [31:0] inst, res, rs2, rdata, input int delay);
        exp_t  e;
        bit    done, timed_out;
        string kind;
        e = model(inst, res, rs2, rdata);
        done = 1'b0;
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_inst = inst; ex_result = res; ex_rs2_data = rs2;
        @(negedge clk);
        check("ready_idle", ex_ready, 1);
        check("wb_pulse", wb_valid, 0);
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_inst = $urandom; ex_result = $urandom; ex_rs2_data = $urandom;
        @(negedge clk);
        if (!e.mem || e.mis) begin
            check("req_none", dmem_req, 0);
            kind = e.mis ? "misalign" : "alu";
        end else begin
            check("req_up", dmem_req, 1);
            check("req_we", dmem_we, inst[6:0] == STORE);
            check("req_addr", dmem_addr, res & 32'hFFFF_FFFC);
            check("req_wstrb", dmem_wstrb, e.wstrb);
            if (inst[6:0] == STORE) check("req_wdata", dmem_wdata, e.wdata);
            check("ready_busy", ex_ready, 0);
            check("wb_quiet", wb_valid, 0);
            last_addr = dmem_addr; last_wdata = dmem_wdata; last_wstrb = dmem_wstrb;
            for (int c = 0; c < TO && !done; c++) begin
                if (c > 0) begin
                    @(negedge clk);
                    check("req_held", dmem_req, 1);
                    check("addr_held", dmem_addr, res & 32'hFFFF_FFFC);
                end
                if (c == delay) begin
                    dmem_ack = 1'b1; dmem_rdata = rdata;
                    @(posedge clk); #1;
                    dmem_ack = 1'b0; dmem_rdata = $urandom;
                    done = 1'b1;
                end else begin
                    @(posedge clk);
                end
            end
            @(negedge clk);
            kind = done ? "access" : "timeout";
        end
        timed_out = e.mem && !e.mis && !done;
        check("wb_valid", wb_valid, 1);
        check("wb_rd", wb_rd, inst[11:7]);
        check("wb_we", wb_we, timed_out ? 1'b0 : e.we);
        if (!timed_out) check("wb_data", wb_data, e.data);
        check("exc_misalign", exc_misalign, e.mis);
        check("exc_timeout", exc_timeout, timed_out);
        check("req_down", dmem_req, 0);
        check("ready_after", ex_ready, 1);
        last_data = wb_data;
        n_txn++;
        $display("txn %0d %s inst=%h res=%h wb_we=%0b wb_data=%h", n_txn, kind, inst, res, wb_we, wb_data);
    endtask

    initial begin
        logic [31:0] r_inst, r_res, r_word;
        logic [6:0]  opcs [8];
        opcs = '{ALU, ALUI, LUI, AUIPC, BR, JAL, LOAD, STORE};

        // Reset values
        @(negedge clk);
        check("rst_ready", ex_ready, 1);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_req", dmem_req, 0);
        check("rst_wstrb", dmem_wstrb, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_exc", {exc_misalign, exc_timeout}, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // ADD rd=5
        do_txn(32'h0000_0033 | (5 << 7), 32'h42, 32'h0, 32'h0, 0);
        check("add_data", last_data, 32'h42);

        // Three back-to-back ALU ops retire one per cycle
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i < 3) begin
                ex_valid = 1'b1; ex_inst = 32'h33 | ((i + 1) << 7); ex_result = 32'h100 + i;
            end else ex_valid = 1'b0;
            @(negedge clk);
            check("b2b_ready", ex_ready, 1);
            check("b2b_valid", wb_valid, i > 0);
            if (i > 0) begin
                check("b2b_rd", wb_rd, i);
                check("b2b_data", wb_data, 32'h100 + i - 1);
                $display("txn b2b retire rd=%0d wb_data=%h", wb_rd, wb_data);
            end
        end

        // LB 0x1003, ack after 2 cycles
        do_txn({17'h0, 3'b000, 5'd1, LOAD}, 32'h1003, 32'h0, 32'h80FF_0000, 2);
        check("lb_addr", last_addr, 32'h1000);
        check("lb_wstrb", last_wstrb, 0);
        check("lb_data", last_data, 32'hFFFF_FF80);

        // SH 0x2002
        do_txn({17'h0, 3'b001, 5'd0, STORE}, 32'h2002, 32'h1234_ABCD, 32'h0, 1);
        check("sh_wdata", last_wdata, 32'hABCD_ABCD);
        check("sh_wstrb", last_wstrb, 4'b1100);

        // Misaligned LW
        do_txn({17'h0, 3'b010, 5'd7, LOAD}, 32'h3001, 32'h0, 32'h0, 0);
        check("lw_mis_data", last_data, 32'h3001);

        // LW never acked, then ADD
        do_txn({17'h0, 3'b010, 5'd8, LOAD}, 32'h5000, 32'h0, 32'h0, 99);
        do_txn(32'h0000_0033 | (9 << 7), 32'h77, 32'h0, 32'h0, 0);

        // Ack while idle is ignored
        @(posedge clk); #1 dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1 dmem_ack = 1'b0;
        @(negedge clk);
        check("idle_ack_wb", wb_valid, 0);
        check("idle_ack_ready", ex_ready, 1);

        // Reset in the middle of an access
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_inst = {17'h0, 3'b010, 5'd3, LOAD}; ex_result = 32'h4000;
        @(posedge clk); #1 ex_valid = 1'b0;
        @(negedge clk);
        check("rstmid_req_up", dmem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_req_drop", dmem_req, 0);
        check("rstmid_ready", ex_ready, 1);
        @(posedge clk); #1 rst_n = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
        @(posedge clk); #1 dmem_ack = 1'b0;
        @(negedge clk);
        check("rstmid_no_wb", wb_valid, 0);
        check("rstmid_ready2", ex_ready, 1);
        check("rstmid_req_idle", dmem_req, 0);
        $display("txn reset-abort done");

        // Randomized instruction mix
        for (int n = 0; n < 150; n++) begin
            r_inst = $urandom;
            r_inst[6:0] = opcs[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) == 0) r_inst[11:7] = 5'd0;
            if (r_inst[6:0] == LOAD || r_inst[6:0] == STORE) begin
                if ($urandom_range(0, 3) != 0) r_inst[14:12] = 3'($urandom_range(0, 2));
            end
            r_res = $urandom;
            if ($urandom_range(0, 1) == 1) r_res[1:0] = 2'b00;
            r_word = $urandom;
            do_txn(r_inst, r_res, $urandom, r_word, ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, TO - 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
